// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and
// queues returned instructions for IF/ID, discarding wrong-path responses.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_OUT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        j_flush,
   input  logic [31:0] j_target,
   input  logic        b_flush,
   input  logic [31:0] b_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CW = $clog2(MAX_OUT + 1);
   localparam int unsigned BW = $clog2(DEPTH + 1);

   logic [31:0]   r_pc;
   logic [31:0]   r_pend [MAX_OUT];
   logic [PW-1:0] r_pend_wr;
   logic [PW-1:0] r_pend_rd;
   logic [CW-1:0] r_out_cnt;
   logic [CW-1:0] r_disc_cnt;
   logic [31:0]   r_buf_pc   [DEPTH];
   logic [31:0]   r_buf_inst [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [BW-1:0] r_buf_cnt;

   logic          w_flush;
   logic [31:0]   w_target;
   logic [31:0]   w_inflight;
   logic          w_grant;
   logic          w_resp;
   logic          w_keep;
   logic          w_pop;

   assign w_flush  = j_flush | b_flush;
   // Branch comes from the older instruction, so it wins over a jump.
   assign w_target = b_flush ? b_target : j_target;

   // Credits count buffered entries plus responses that will still land.
   assign w_inflight = 32'(r_buf_cnt) + 32'(r_out_cnt) - 32'(r_disc_cnt);
   assign imem_req   = !rst && !w_flush && (32'(r_out_cnt) < MAX_OUT) && (w_inflight < DEPTH);
   assign imem_addr  = r_pc;

   assign w_grant = imem_req && imem_gnt;
   assign w_resp  = imem_rvalid && (r_out_cnt != '0);
   assign w_keep  = w_resp && (r_disc_cnt == '0) && !w_flush;
   assign w_pop   = if_valid && !stall;

   assign if_valid = (r_buf_cnt != '0);
   assign if_pc    = if_valid ? r_buf_pc[r_head]   : '0;
   assign if_inst  = if_valid ? r_buf_inst[r_head] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_pend_wr  <= '0;
         r_pend_rd  <= '0;
         r_out_cnt  <= '0;
         r_disc_cnt <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_buf_cnt  <= '0;
      end else begin
         if (w_grant)
            r_pend_wr <= (r_pend_wr == PW'(MAX_OUT - 1)) ? '0 : r_pend_wr + PW'(1);
         if (w_resp)
            r_pend_rd <= (r_pend_rd == PW'(MAX_OUT - 1)) ? '0 : r_pend_rd + PW'(1);
         r_out_cnt <= r_out_cnt + CW'(w_grant) - CW'(w_resp);

         if (w_flush) begin
            // Everything still outstanding after this cycle is wrong-path.
            r_pc       <= w_target;
            r_disc_cnt <= r_out_cnt - CW'(w_resp);
            r_head     <= '0;
            r_tail     <= '0;
            r_buf_cnt  <= '0;
         end else begin
            if (w_grant)
               r_pc <= r_pc + 32'd4;
            if (w_resp && (r_disc_cnt != '0))
               r_disc_cnt <= r_disc_cnt - CW'(1);
            if (w_keep)
               r_tail <= r_tail + AW'(1);
            if (w_pop)
               r_head <= r_head + AW'(1);
            r_buf_cnt <= r_buf_cnt + BW'(w_keep) - BW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_grant)
         r_pend[r_pend_wr] <= r_pc;
      if (!rst && w_keep) begin
         r_buf_pc[r_tail]   <= r_pend[r_pend_rd];
         r_buf_inst[r_tail] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: queue-based reference model plus directed and random
// phases driven against an in-order memory responder with variable latency.
module tb_if_fetch;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned MAX_OUT = 2;
   localparam logic [31:0] K       = 32'hA5A5_0000;

   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   typedef struct { logic [31:0] a; int rdy; } mreq_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        j_flush = 1'b0, b_flush = 1'b0, stall = 1'b0;
   logic [31:0] j_target = '0, b_target = '0;
   logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_pc, if_inst;

   // second instance for the reset-PC wrap case
   logic        w_rst = 1'b1, w_gnt = 1'b0, w_rvalid = 1'b0, z1 = 1'b0;
   logic [31:0] w_rdata = '0, z32 = '0;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_pc, w_inst;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int lat    = 1;
   int gmode  = 0;
   bit chk_en = 1'b0;

   ent_t        mbuf[$];
   logic [31:0] mpend[$];
   int          mdisc = 0;
   logic [31:0] mpc   = '0;
   mreq_t       mq[$];

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .j_flush(j_flush), .j_target(j_target),
      .b_flush(b_flush), .b_target(b_target), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst));

   if_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) u_wrap (
      .clk(clk), .rst(w_rst), .j_flush(z1), .j_target(z32),
      .b_flush(z1), .b_target(z32), .stall(z1),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .if_valid(w_valid), .if_pc(w_pc), .if_inst(w_inst));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic bit model_req();
      return !rst && !(j_flush || b_flush) && (mpend.size() < MAX_OUT) &&
             ((mbuf.size() + mpend.size() - mdisc) < DEPTH);
   endfunction

   task automatic compare();
      bit ev;
      ev = (mbuf.size() != 0);
      chk("if_valid", {31'b0, if_valid}, {31'b0, ev});
      chk("if_pc", if_pc, ev ? mbuf[0].pc : 32'h0);
      chk("if_inst", if_inst, ev ? mbuf[0].inst : 32'h0);
      chk("imem_req", {31'b0, imem_req}, {31'b0, model_req()});
      chk("imem_addr", imem_addr, mpc);
   endtask

   // Advances the model across the coming rising edge using current inputs.
   task automatic model_step();
      bit          resp, grant;
      logic [31:0] a;
      if (rst) begin
         mpc = 32'h0; mpend.delete(); mbuf.delete(); mdisc = 0;
      end else begin
         resp = imem_rvalid && (mpend.size() != 0);
         if (j_flush || b_flush) begin
            if (resp) void'(mpend.pop_front());
            mdisc = mpend.size();
            mbuf.delete();
            mpc = b_flush ? b_target : j_target;
         end else begin
            grant = model_req() && imem_gnt;
            if (mbuf.size() != 0 && !stall) void'(mbuf.pop_front());
            if (resp) begin
               a = mpend.pop_front();
               if (mdisc > 0) mdisc--;
               else mbuf.push_back('{a, imem_rdata});
            end
            if (grant) begin
               mpend.push_back(mpc);
               mpc = mpc + 32'd4;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_en) compare();
      if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
      model_step();
      @(posedge clk);
      cyc++;
      #1;
      j_flush = 1'b0;
      b_flush = 1'b0;
      case (gmode)
         0:       imem_gnt = 1'b1;
         1:       imem_gnt = 1'b0;
         default: imem_gnt = ($urandom_range(3) != 0);
      endcase
      if (mq.size() != 0 && mq[0].rdy <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mq[0].a ^ K;
         void'(mq.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom();
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset and stream
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("start_req", {31'b0, imem_req}, 32'd1);
      chk("start_addr", imem_addr, 32'h0);
      tick(); #1;
      chk("early_valid", {31'b0, if_valid}, 32'd0);
      tick(); #1;
      chk("first_valid", {31'b0, if_valid}, 32'd1);
      chk("first_pc", if_pc, 32'h0);
      chk("first_inst", if_inst, 32'hA5A5_0000);
      tick(); #1;
      chk("second_pc", if_pc, 32'h4);
      chk("second_inst", if_inst, 32'hA5A5_0004);
      tick(); #1;
      chk("third_pc", if_pc, 32'h8);

      // stall hold
      stall = 1'b1;
      repeat (4) tick();
      #1;
      chk("stall_req_low", {31'b0, imem_req}, 32'd0);
      chk("stall_pc_held", if_pc, 32'h8);
      tick();
      stall = 1'b0;
      repeat (8) tick();

      // simultaneous redirects
      j_flush = 1'b1; j_target = 32'h200;
      b_flush = 1'b1; b_target = 32'h300;
      tick(); #1;
      chk("dual_flush_addr", imem_addr, 32'h300);
      chk("dual_flush_valid", {31'b0, if_valid}, 32'd0);
      repeat (6) tick();

      // grant backpressure
      gmode = 1; imem_gnt = 1'b0;
      j_flush = 1'b1; j_target = 32'h400;
      tick();
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_addr_held", imem_addr, 32'h400);
         tick();
      end
      gmode = 0; imem_gnt = 1'b1;
      #1;
      chk("bp_addr_grant", imem_addr, 32'h400);
      tick(); #1;
      chk("bp_addr_adv", imem_addr, 32'h404);
      repeat (4) tick();

      // branch with requests in flight
      lat = 3;
      repeat (6) tick();
      b_flush = 1'b1; b_target = 32'h100;
      tick();
      for (int k = 0; k < 20; k++) begin
         if (if_valid) break;
         tick();
      end
      chk("br_valid", {31'b0, if_valid}, 32'd1);
      chk("br_pc", if_pc, 32'h100);
      chk("br_inst", if_inst, 32'h100 ^ K);
      repeat (6) tick();

      // mid-run reset with outstanding requests, stale responses afterwards
      rst = 1'b1;
      tick(); #1;
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      rst = 1'b0; gmode = 1; imem_gnt = 1'b0;
      repeat (5) tick();
      #1;
      chk("stale_ignored", {31'b0, if_valid}, 32'd0);
      gmode = 0;
      lat = 1;
      repeat (4) tick();

      // randomized traffic
      gmode = 2;
      for (int n = 0; n < 2500; n++) begin
         tick();
         if (n % 300 == 0) lat = 1 + int'($urandom_range(3));
         stall = ($urandom_range(3) == 0);
         rst   = ($urandom_range(199) == 0);
         if ($urandom_range(24) == 0) begin
            b_flush  = $urandom_range(1) != 0;
            j_flush  = !b_flush || ($urandom_range(1) != 0);
            b_target = $urandom() & 32'hFFFF_FFFC;
            j_target = $urandom() & 32'hFFFF_FFFC;
         end
      end
      rst = 1'b0; stall = 1'b0; gmode = 0;
      repeat (10) tick();

      // wrap past 2^32 from a high reset PC
      w_rst = 1'b0; w_gnt = 1'b1; w_rvalid = 1'b0;
      #1;
      chk("wrap_req", {31'b0, w_req}, 32'd1);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
      tick();
      w_rvalid = 1'b1; w_rdata = 32'hFFFF_FFF8 ^ K;
      #1;
      chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
      tick();
      w_rvalid = 1'b1; w_rdata = 32'hFFFF_FFFC ^ K;
      #1;
      chk("wrap_addr2", w_addr, 32'h0000_0000);
      chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
      chk("wrap_inst0", w_inst, 32'h5A5A_FFF8);
      tick();
      w_rvalid = 1'b1; w_rdata = 32'h0 ^ K; w_gnt = 1'b0;
      #1;
      chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
      tick();
      w_rvalid = 1'b0;
      #1;
      chk("wrap_valid2", {31'b0, w_valid}, 32'd1);
      chk("wrap_pc2", w_pc, 32'h0000_0000);
      chk("wrap_inst2", w_inst, 32'hA5A5_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
